// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module : seq_det_pkg
// Brief  : State encoding shared by the serial sequence detectors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int C_STATE_W = 2;

  localparam logic [C_STATE_W-1:0] S0  = 2'd0;  // no useful prefix
  localparam logic [C_STATE_W-1:0] S1  = 2'd1;  // last bit '1'
  localparam logic [C_STATE_W-1:0] S10 = 2'd2;  // last bits '1,0'

  typedef enum logic [C_STATE_W-1:0] {
    ST_S0  = S0,
    ST_S1  = S1,
    ST_S10 = S10
  } state_e;

endpackage : seq_det_pkg

`default_nettype wire

// File: rtl/seq_101_det.sv
// ============================================================================
// Module : seq_101_det
// Brief  : Serial "1,0,1" detector with a registered one-cycle match flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_101_det
  import seq_det_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic flag_101
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_flag;
  logic   w_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_S0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flag  <= w_match;
    end
  end

  // Unlisted codes (including 3) fall through to S0 with no match.
  always_comb begin
    w_state_nxt = ST_S0;
    w_match     = 1'b0;
    case (r_state)
      ST_S0:  w_state_nxt = data_in ? ST_S1 : ST_S0;
      ST_S1:  w_state_nxt = data_in ? ST_S1 : ST_S10;
      ST_S10: begin
        if (data_in) begin
          w_match     = 1'b1;
          w_state_nxt = OVERLAP ? ST_S1 : ST_S0;
        end else begin
          w_state_nxt = ST_S0;
        end
      end
      default: begin
        w_state_nxt = ST_S0;
        w_match     = 1'b0;
      end
    endcase
  end

  assign flag_101 = r_flag;

`ifndef SYNTHESIS
  a_no_double_flag : assert property (@(posedge clk) disable iff (rst)
    flag_101 |=> !flag_101);
  a_flag_low_in_rst : assert property (@(posedge clk) rst |-> !flag_101);
`endif

endmodule : seq_101_det

`default_nettype wire

// File: tb/tb_seq_101_det.sv
// ============================================================================
// Module : tb_seq_101_det
// Brief  : Scoreboard bench running OVERLAP=1 and OVERLAP=0 detectors in parallel.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_101_det;
  import seq_det_pkg::*;

  logic clk;
  logic rst;
  logic data_in;
  logic flag1;
  logic flag0;

  int n_cmp = 0;
  int n_bad = 0;
  int step  = 0;

  // Expected {flag with OVERLAP=1, flag with OVERLAP=0} per sampling edge.
  logic [1:0] exp_q[$];

  // Reference model: 3-bit history plus count of samples since last clear.
  logic [2:0] sh1, sh0;
  int         cnt1, cnt0;

  seq_101_det #(.OVERLAP(1'b1)) dut_ov1 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .flag_101 (flag1)
  );

  seq_101_det #(.OVERLAP(1'b0)) dut_ov0 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .flag_101 (flag0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_step(input logic b, output logic m1, output logic m0);
    sh1 = {sh1[1:0], b};
    cnt1++;
    m1 = (cnt1 >= 3) && (sh1 == 3'b101);
    sh0 = {sh0[1:0], b};
    cnt0++;
    m0 = (cnt0 >= 3) && (sh0 == 3'b101);
    if (m0) cnt0 = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    check("rst flag ov1", {1'b0, flag1}, 2'b00);
    check("rst flag ov0", {1'b0, flag0}, 2'b00);
    check("rst state ov1", dut_ov1.r_state, S0);
    repeat (n) begin
      data_in = ~data_in;
      exp_q.push_back(2'b00);
      @(negedge clk);
    end
    rst  = 1'b0;
    sh1  = 3'b000;
    sh0  = 3'b000;
    cnt1 = 0;
    cnt0 = 0;
  endtask

  task automatic drive_hand(input logic b, input logic e1, input logic e0);
    logic m1, m0;
    data_in = b;
    model_step(b, m1, m0);
    exp_q.push_back({e1, e0});
    @(negedge clk);
  endtask

  task automatic drive_model(input logic b);
    logic m1, m0;
    data_in = b;
    model_step(b, m1, m0);
    exp_q.push_back({m1, m0});
    @(negedge clk);
  endtask

  // Bits are sent MSB first (oldest bit first); e1/e0 give the flag per bit.
  task automatic run_vec(input logic [15:0] bits, input logic [15:0] e1,
                         input logic [15:0] e0, input int len);
    for (int i = len - 1; i >= 0; i--) drive_hand(bits[i], e1[i], e0[i]);
  endtask

  initial begin : monitor
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("flag ov1 step %0d", step), {1'b0, flag1}, {1'b0, e[1]});
        check($sformatf("flag ov0 step %0d", step), {1'b0, flag0}, {1'b0, e[0]});
        step++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst     = 1'b1;
    data_in = 1'b0;
    sh1 = 3'b000; sh0 = 3'b000; cnt1 = 0; cnt0 = 0;
    @(negedge clk);
    do_reset(4);

    run_vec(16'b101,   16'b001,   16'b001,   3);
    do_reset(2);
    run_vec(16'b10101, 16'b00101, 16'b00100, 5);
    do_reset(2);
    run_vec(16'b11001, 16'b00000, 16'b00000, 5);
    do_reset(2);
    run_vec(16'b00011, 16'b00000, 16'b00000, 5);
    do_reset(2);
    run_vec(16'b1101,  16'b0001,  16'b0001,  4);

    // Reset lands while the flag from "1101" is high; history must also be lost.
    do_reset(2);
    run_vec(16'b10, 16'b00, 16'b00, 2);
    do_reset(2);
    drive_hand(1'b1, 1'b0, 1'b0);
    drive_hand(1'b0, 1'b0, 1'b0);
    drive_hand(1'b1, 1'b1, 1'b1);

    do_reset(4);
    for (int i = 0; i < 100; i++) drive_model(1'($urandom_range(0, 1)));

    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_101_det

`default_nettype wire
